booth_mul_arbiter: RTL and testbench

Shares one signed 8x8 radix-4 Booth multiplier among N_REQ requesters. Uses round-robin arbitration with a valid/ready handshake on each request port and a two-stage pipeline with backpressure. Returns one tagged 16-bit product per accepted request, in issue order. Sits between the tile's compute requesters and the single multiplier instance, so no requester owns the datapath directly.

---
 rtl/booth_arb_pkg.sv | 20 ++
 rtl/booth_mul8.sv | 49 ++++
 rtl/booth_mul_arbiter.sv | 117 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// Shared constants and radix-4 Booth digit encoding for the arbitrated multiplier.
package booth_arb_pkg;
    localparam int unsigned MUL_W  = 8;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [2:0] {ZERO, P1, M1, P2, M2} booth_digit_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}; the digit is one of -2..+2.
    function automatic booth_digit_e booth_encode(input logic [2:0] win);
        booth_digit_e d;
        case (win)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/booth_mul8.sv
// Combinational signed 8x8 -> 16 radix-4 Booth multiplier with a carry-save reduction tree.
module booth_mul8
    import booth_arb_pkg::*;
(
    input  logic [MUL_W-1:0]  a_i,
    input  logic [MUL_W-1:0]  b_i,
    output logic [PROD_W-1:0] prod_o
);
    localparam int unsigned NumPp = MUL_W / 2;
    // Two extra bits so that -(-128) and 2*(-128) are representable.
    localparam int unsigned PpW   = MUL_W + 2;

    logic [MUL_W:0]    b_ext;
    logic [PpW-1:0]    a_x1;
    logic [PpW-1:0]    a_x2;
    logic [PROD_W-1:0] pp [NumPp];

    assign b_ext = {b_i, 1'b0};
    assign a_x1  = {{2{a_i[MUL_W-1]}}, a_i};
    assign a_x2  = {a_i[MUL_W-1], a_i, 1'b0};

    for (genvar g = 0; g < NumPp; g++) begin : g_pp
        booth_digit_e   dig;
        logic [PpW-1:0] sel;

        assign dig = booth_encode(b_ext[2*g +: 3]);

        always_comb begin
            sel = '0;
            case (dig)
                P1:      sel = a_x1;
                M1:      sel = ~a_x1 + PpW'(1);
                P2:      sel = a_x2;
                M2:      sel = ~a_x2 + PpW'(1);
                default: sel = '0;
            endcase
        end

        assign pp[g] = {{(PROD_W - PpW){sel[PpW-1]}}, sel} << (2 * g);
    end

    logic [PROD_W-1:0] sum0, cry0, sum1, cry1;

    assign sum0   = pp[0] ^ pp[1] ^ pp[2];
    assign cry0   = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign sum1   = sum0 ^ cry0 ^ pp[3];
    assign cry1   = ((sum0 & cry0) | (sum0 & pp[3]) | (cry0 & pp[3])) << 1;
    assign prod_o = sum1 + cry1;
endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier across N_REQ requesters through a
// two-stage valid/ready pipeline; responses return tagged and in acceptance order.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [MUL_W*N_REQ-1:0] req_a_i,
    input  logic [MUL_W*N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [PROD_W-1:0]      rsp_prod_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o
);
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [MUL_W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d, mul_prod;

    logic              s2_load, can_accept, accept, grant_any;
    logic [ID_W-1:0]   grant_id, idx;
    logic [MUL_W-1:0]  a_arr [N_REQ];
    logic [MUL_W-1:0]  b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a_i[g*MUL_W +: MUL_W];
        assign b_arr[g] = req_b_i[g*MUL_W +: MUL_W];
    end

    assign s2_load    = !s2_valid_q || rsp_ready_i;
    assign can_accept = !s1_valid_q || s2_load;

    // Search starts one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!grant_any && req_valid_i[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // rst_n term keeps every grant low while reset is held.
    assign accept      = rst_n && can_accept && grant_any;
    assign req_ready_o = accept ? (N_REQ'(1) << grant_id) : '0;

    booth_mul8 u_mul (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .prod_o (mul_prod)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;
        if (can_accept) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d  = a_arr[grant_id];
                s1_b_d  = b_arr[grant_id];
                s1_id_d = grant_id;
                ptr_d   = grant_id;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = mul_prod;
                s2_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= '0;
            ptr_q      <= ID_W'(N_REQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign rsp_valid_o = s2_valid_q;
    assign rsp_id_o    = s2_id_q;
    assign rsp_prod_o  = s2_prod_q;
    assign busy_o      = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed corner sequences plus a random run scored
// against a queue-based model of grants, ordering and products.
module tb_booth_mul_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [7:0]           a_arr [N_REQ];
    logic [7:0]           b_arr [N_REQ];
    logic [8*N_REQ-1:0]   req_a, req_b;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_prod;
    logic                 rsp_ready;
    logic                 busy;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_a[g*8 +: 8] = a_arr[g];
        assign req_b[g*8 +: 8] = b_arr[g];
    end

    booth_mul_arbiter #(.N_REQ(N_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_prod_o  (rsp_prod),
        .rsp_ready_i (rsp_ready),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] prod;
        int          edge_n;
    } item_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_prod;
    } vec_t;

    item_t            q[$];
    int               ptr_m;
    int               edge_cnt;
    int               checks;
    int               failures;
    int               accepts;
    int               wait_cnt [N_REQ];
    logic [N_REQ-1:0] hs_vec;
    vec_t             vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [N_REQ-1:0] v, input int i);
        logic [N_REQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic set_req(input int i, input bit v, input logic [7:0] a, input logic [7:0] b);
        a_arr[i] = a;
        b_arr[i] = b;
        if (v) req_valid = req_valid | (N_REQ'(1) << i);
        else   req_valid = req_valid & ~(N_REQ'(1) << i);
    endtask

    task automatic model_reset();
        q.delete();
        ptr_m = N_REQ - 1;
        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    endtask

    // Up to two products can be in flight; the oldest is visible once two edges old.
    task automatic model_check();
        bit                can_acc, found, exp_rv, rsp_hs;
        int                g, c;
        logic [N_REQ-1:0]  exp_ready;
        logic signed [7:0] sa, sb;
        logic signed [15:0] p;
        can_acc = (q.size() < 2) || rsp_ready;
        found   = 1'b0;
        g       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = (ptr_m + k) % N_REQ;
            if (!found && bit_at(req_valid, c)) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_ready = (can_acc && found) ? (N_REQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rv = (q.size() > 0) && (edge_cnt >= q[0].edge_n + 1);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (exp_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_prod", 32'(rsp_prod), 32'(q[0].prod));
        end
        rsp_hs = exp_rv && rsp_ready;
        hs_vec = exp_ready & req_valid;
        for (int i = 0; i < N_REQ; i++) begin
            if (!bit_at(req_valid, i) || (hs_vec != 0 && i == g)) begin
                wait_cnt[i] = 0;
            end else if (hs_vec != 0) begin
                wait_cnt[i]++;
                chk("fairness_wait_ok", 32'(wait_cnt[i] <= N_REQ - 1), 32'd1);
            end
        end
        if (rsp_hs) void'(q.pop_front());
        if (hs_vec != 0) begin
            sa = a_arr[g];
            sb = b_arr[g];
            p  = sa * sb;
            q.push_back('{g, p, edge_cnt + 1});
            ptr_m = g;
            accepts++;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic step();
        at_neg();
        to_next();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        edge_cnt += 2;
        rst_n = 1'b1;
    endtask

    initial begin
        int n_acc, start_acc, cyc;
        checks   = 0;
        failures = 0;
        edge_cnt = 0;
        accepts  = 0;
        hs_vec   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        model_reset();

        // Reset state, with requests pending to show grants are suppressed.
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: 7 * -3 from requester 1.
        set_req(1, 1'b1, 8'd7, 8'hFD);
        at_neg();
        chk("t1_grant", 32'(req_ready), 32'b0010);
        to_next();
        set_req(1, 1'b0, 8'd7, 8'hFD);
        at_neg();
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        to_next();
        at_neg();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd1);
        chk("t1_rsp_prod", 32'(rsp_prod), 32'h0000FFEB);
        to_next();

        // All four streaming: round-robin from requester 0, full throughput.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd10);
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk("t2_grant", 32'(req_ready), 32'(N_REQ'(1) << (k % 4)));
            if (k >= 2) begin
                chk("t2_rsp_id", 32'(rsp_id), 32'(k - 2));
                chk("t2_rsp_prod", 32'(rsp_prod), 32'(10 * (k - 1)));
            end
            to_next();
        end
        req_valid = '0;
        repeat (3) step();

        // Corner operands, one at a time through requester 2.
        vt[0] = '{8'h80, 8'h80, 16'h4000};
        vt[1] = '{8'h80, 8'h7F, 16'hC080};
        vt[2] = '{8'h7F, 8'h7F, 16'h3F01};
        vt[3] = '{8'h00, 8'hFF, 16'h0000};
        vt[4] = '{8'hFF, 8'hFF, 16'h0001};
        vt[5] = '{8'h7F, 8'h80, 16'hC080};
        vt[6] = '{8'h55, 8'hAA, 16'hE372};
        vt[7] = '{8'h0D, 8'hF3, 16'hFF57};
        for (int v = 0; v < 8; v++) begin
            set_req(2, 1'b1, vt[v].a, vt[v].b);
            step();
            set_req(2, 1'b0, vt[v].a, vt[v].b);
            step();
            at_neg();
            chk("t3_rsp_prod", 32'(rsp_prod), 32'(vt[v].exp_prod));
            chk("t3_rsp_id", 32'(rsp_id), 32'd2);
            to_next();
        end

        // Backpressure: two accepts fill both stages, then grants stop.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'd3, 8'd4);
        set_req(1, 1'b1, 8'hFB, 8'd6);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            n_acc += $countones(req_ready & req_valid);
            if (k >= 2) begin
                chk("t4_stall_ready", 32'(req_ready), 32'd0);
                chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
                chk("t4_hold_id", 32'(rsp_id), 32'd0);
                chk("t4_hold_prod", 32'(rsp_prod), 32'd12);
            end
            to_next();
        end
        chk("t4_accepts", 32'(n_acc), 32'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        at_neg();
        chk("t4_first_id", 32'(rsp_id), 32'd0);
        chk("t4_first_prod", 32'(rsp_prod), 32'd12);
        to_next();
        at_neg();
        chk("t4_second_id", 32'(rsp_id), 32'd1);
        chk("t4_second_prod", 32'(rsp_prod), 32'h0000FFE2);
        to_next();
        step();

        // Asynchronous reset with both stages full; pointer returns to favour requester 0.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'd2, 8'd3);
        set_req(1, 1'b1, 8'd4, 8'd5);
        step();
        step();
        set_req(1, 1'b0, 8'd4, 8'd5);
        set_req(2, 1'b1, 8'd9, 8'd9);
        #2;
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid_async", 32'(rsp_valid), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_ready_in_reset", 32'(req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        edge_cnt++;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        at_neg();
        chk("t5_first_grant", 32'(req_ready), 32'b0001);
        to_next();
        set_req(0, 1'b0, 8'd2, 8'd3);
        step();
        set_req(2, 1'b0, 8'd9, 8'd9);
        repeat (3) step();

        // Random traffic: requesters hold until granted, may withdraw, rsp_ready random.
        start_acc = accepts;
        cyc       = 0;
        while ((accepts - start_acc < 10000) && (cyc < 40000)) begin
            at_neg();
            to_next();
            for (int i = 0; i < N_REQ; i++) begin
                if (bit_at(hs_vec, i)) begin
                    set_req(i, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
                end else if (bit_at(req_valid, i)) begin
                    if ($urandom_range(0, 31) == 0) set_req(i, 1'b0, a_arr[i], b_arr[i]);
                end else if ($urandom_range(0, 1) == 1) begin
                    set_req(i, 1'b1, 8'($urandom), 8'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("t6_all_accepted", 32'(accepts - start_acc >= 10000), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("t6_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
